// File: rtl/idex_pkg.sv
// Shared ID/EX definitions: ALU function codes, forwarding selects
// and the EX pipeline register bundle.
package idex_pkg;

   localparam logic [5:0] ALU_SLL  = 6'b000000;
   localparam logic [5:0] ALU_SRL  = 6'b000010;
   localparam logic [5:0] ALU_SLLV = 6'b000100;
   localparam logic [5:0] ALU_ADDI = 6'b001000;
   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_SUB  = 6'b100010;
   localparam logic [5:0] ALU_AND  = 6'b100100;
   localparam logic [5:0] ALU_OR   = 6'b100101;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_EXM = 2'd1,
      FWD_MWB = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [15:0] imm;
      logic [4:0]  shamt;
      logic [5:0]  functn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        alu_src;
      logic        imm_zext;
      logic        shift_imm;
      logic        shift_var;
      logic        is_lui;
   } id_ex_t;

endpackage

// File: rtl/idex_stage_fwd_mux.sv
// Operand bypass: picks the youngest in-flight writer of a source
// register, falling back to the register-file value.
module fwd_mux
   import idex_pkg::*;
(
   input  logic [4:0]  src_i,
   input  logic [31:0] reg_val_i,
   input  logic        exm_reg_write_i,
   input  logic [4:0]  exm_dest_i,
   input  logic [31:0] exm_result_i,
   input  logic        mwb_reg_write_i,
   input  logic [4:0]  mwb_dest_i,
   input  logic [31:0] mwb_result_i,
   output logic [31:0] val_o
);

   fwd_sel_e sel;

   always_comb begin
      sel = FWD_REG;
      if (exm_reg_write_i && exm_dest_i != 5'd0 && exm_dest_i == src_i)
         sel = FWD_EXM;
      else if (mwb_reg_write_i && mwb_dest_i != 5'd0 && mwb_dest_i == src_i)
         sel = FWD_MWB;
   end

   always_comb begin
      val_o = reg_val_i;
      unique case (sel)
         FWD_EXM: val_o = exm_result_i;
         FWD_MWB: val_o = mwb_result_i;
         default: val_o = reg_val_i;
      endcase
   end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall, flush, operand
// forwarding and ALU operand selection.
module idex_stage
   import idex_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [31:0] id_rs_val,
   input  logic [31:0] id_rt_val,
   input  logic [15:0] id_imm,
   input  logic [4:0]  id_shamt,
   input  logic [5:0]  id_functn,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_dest,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_alu_src,
   input  logic        id_imm_zext,
   input  logic        id_shift_imm,
   input  logic        id_shift_var,
   input  logic        id_is_lui,
   input  logic        flush,
   input  logic        exm_reg_write,
   input  logic [4:0]  exm_dest,
   input  logic [31:0] exm_result,
   input  logic        mwb_reg_write,
   input  logic [4:0]  mwb_dest,
   input  logic [31:0] mwb_result,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [5:0]  alu_functn,
   output logic        ex_valid,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic [4:0]  ex_dest,
   output logic [31:0] ex_store_data,
   output logic        id_stall,
   output logic [31:0] stall_count
);

   id_ex_t      ex_q, ex_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] fwd_rs, fwd_rt;
   logic        id_reads_rt;

   assign id_reads_rt = !id_alu_src || id_shift_imm
                     || id_shift_var || id_mem_write;

   assign id_stall = id_valid && ex_q.valid && ex_q.mem_read
                  && ex_q.dest != 5'd0
                  && (ex_q.dest == id_rs
                      || (id_reads_rt && ex_q.dest == id_rt));

   always_comb begin
      ex_d = '0;
      cnt_d = cnt_q;
      if (flush) begin
         ex_d = '0;
      end else if (id_stall) begin
         ex_d = '0;
         if (cnt_q != 32'hFFFF_FFFF)
            cnt_d = cnt_q + 32'd1;
      end else begin
         ex_d.valid     = id_valid;
         ex_d.rs_val    = id_rs_val;
         ex_d.rt_val    = id_rt_val;
         ex_d.imm       = id_imm;
         ex_d.shamt     = id_shamt;
         ex_d.functn    = id_functn;
         ex_d.rs        = id_rs;
         ex_d.rt        = id_rt;
         ex_d.dest      = id_dest;
         ex_d.reg_write = id_reg_write;
         ex_d.mem_read  = id_mem_read;
         ex_d.mem_write = id_mem_write;
         ex_d.alu_src   = id_alu_src;
         ex_d.imm_zext  = id_imm_zext;
         ex_d.shift_imm = id_shift_imm;
         ex_d.shift_var = id_shift_var;
         ex_d.is_lui    = id_is_lui;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   fwd_mux u_fwd_rs (
      .src_i           (ex_q.rs),
      .reg_val_i       (ex_q.rs_val),
      .exm_reg_write_i (exm_reg_write),
      .exm_dest_i      (exm_dest),
      .exm_result_i    (exm_result),
      .mwb_reg_write_i (mwb_reg_write),
      .mwb_dest_i      (mwb_dest),
      .mwb_result_i    (mwb_result),
      .val_o           (fwd_rs)
   );

   fwd_mux u_fwd_rt (
      .src_i           (ex_q.rt),
      .reg_val_i       (ex_q.rt_val),
      .exm_reg_write_i (exm_reg_write),
      .exm_dest_i      (exm_dest),
      .exm_result_i    (exm_result),
      .mwb_reg_write_i (mwb_reg_write),
      .mwb_dest_i      (mwb_dest),
      .mwb_result_i    (mwb_result),
      .val_o           (fwd_rt)
   );

   always_comb begin
      alu_a = fwd_rs;
      unique case (1'b1)
         ex_q.is_lui:                   alu_a = {ex_q.imm, 16'h0};
         ex_q.shift_imm, ex_q.shift_var: alu_a = fwd_rt;
         default:                       alu_a = fwd_rs;
      endcase
   end

   always_comb begin
      alu_b = fwd_rt;
      if (ex_q.is_lui)
         alu_b = 32'd0;
      else if (ex_q.shift_imm)
         alu_b = {27'd0, ex_q.shamt};
      else if (ex_q.shift_var)
         alu_b = {27'd0, fwd_rs[4:0]};
      else if (ex_q.alu_src && ex_q.imm_zext)
         alu_b = {16'd0, ex_q.imm};
      else if (ex_q.alu_src)
         alu_b = {{16{ex_q.imm[15]}}, ex_q.imm};
   end

   assign alu_functn    = ex_q.is_lui ? ALU_OR : ex_q.functn;
   assign ex_valid      = ex_q.valid;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_dest       = ex_q.dest;
   assign ex_store_data = fwd_rt;
   assign stall_count   = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Scenario bench for idex_stage: expected ALU operands are queued
// when an instruction is issued and checked when it reaches EX.
module tb_idex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_rs_val, id_rt_val;
   logic [15:0] id_imm;
   logic [4:0]  id_shamt;
   logic [5:0]  id_functn;
   logic [4:0]  id_rs, id_rt, id_dest;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic        id_alu_src, id_imm_zext, id_shift_imm;
   logic        id_shift_var, id_is_lui;
   logic        flush;
   logic        exm_reg_write;
   logic [4:0]  exm_dest;
   logic [31:0] exm_result;
   logic        mwb_reg_write;
   logic [4:0]  mwb_dest;
   logic [31:0] mwb_result;
   logic [31:0] alu_a, alu_b;
   logic [5:0]  alu_functn;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [4:0]  ex_dest;
   logic [31:0] ex_store_data;
   logic        id_stall;
   logic [31:0] stall_count;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  f;
      logic        v;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] exp_stalls = 32'd0;

   always #5 clk = ~clk;

   idex_stage dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
      .id_imm(id_imm), .id_shamt(id_shamt), .id_functn(id_functn),
      .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
      .id_imm_zext(id_imm_zext), .id_shift_imm(id_shift_imm),
      .id_shift_var(id_shift_var), .id_is_lui(id_is_lui),
      .flush(flush),
      .exm_reg_write(exm_reg_write), .exm_dest(exm_dest),
      .exm_result(exm_result),
      .mwb_reg_write(mwb_reg_write), .mwb_dest(mwb_dest),
      .mwb_result(mwb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_functn(alu_functn),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_dest(ex_dest), .ex_store_data(ex_store_data),
      .id_stall(id_stall), .stall_count(stall_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id;
      id_valid = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
      id_shamt = 0; id_functn = 0; id_rs = 0; id_rt = 0; id_dest = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      id_alu_src = 0; id_imm_zext = 0; id_shift_imm = 0;
      id_shift_var = 0; id_is_lui = 0;
   endtask

   task automatic clear_fwd;
      exm_reg_write = 0; exm_dest = 0; exm_result = 0;
      mwb_reg_write = 0; mwb_dest = 0; mwb_result = 0;
   endtask

   task automatic test_reset;
      reset = 1; flush = 0;
      clear_id(); clear_fwd();
      tick(); tick();
      n_tests++;
      if ({alu_a, alu_b, alu_functn} !== 70'd0) begin
         n_fail++;
         $display("FAIL reset_alu: got a=%h b=%h f=%b, want 0",
                  alu_a, alu_b, alu_functn);
      end
      n_tests++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_dest, ex_store_data} !== 41'd0) begin
         n_fail++;
         $display("FAIL reset_ex: got v=%b rw=%b mr=%b mw=%b d=%0d sd=%h, want 0",
                  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                  ex_dest, ex_store_data);
      end
      n_tests++;
      if (stall_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %0d want 0", stall_count);
      end
      reset = 0;
   endtask

   task automatic test_addi;
      clear_id();
      id_valid = 1; id_rs = 1; id_rs_val = 5; id_imm = 16'hFFFF;
      id_alu_src = 1; id_dest = 2; id_reg_write = 1;
      id_functn = 6'b001000;
      sb.push_back('{a: 32'd5, b: 32'hFFFF_FFFF, f: 6'b001000, v: 1'b1});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (alu_a !== e.a || alu_b !== e.b || alu_functn !== e.f
          || ex_valid !== e.v) begin
         n_fail++;
         $display("FAIL addi: got a=%h b=%h f=%b v=%b want a=%h b=%h f=%b v=%b",
                  alu_a, alu_b, alu_functn, ex_valid, e.a, e.b, e.f, e.v);
      end
   endtask

   task automatic test_forward;
      clear_id();
      id_valid = 1; id_rs = 1; id_rt = 2; id_rs_val = 100;
      id_rt_val = 200; id_dest = 3; id_reg_write = 1;
      id_functn = 6'b100000;
      sb.push_back('{a: 32'd7, b: 32'd200, f: 6'b100000, v: 1'b1});
      tick();
      exm_reg_write = 1; exm_dest = 1; exm_result = 7;
      mwb_reg_write = 1; mwb_dest = 1; mwb_result = 9;
      #1;
      e = sb.pop_front();
      n_tests++;
      if (alu_a !== e.a || alu_b !== e.b || alu_functn !== e.f) begin
         n_fail++;
         $display("FAIL fwd_exm_prio: got a=%h b=%h f=%b want a=%h b=%h f=%b",
                  alu_a, alu_b, alu_functn, e.a, e.b, e.f);
      end
      exm_reg_write = 0; mwb_dest = 2;
      #1;
      n_tests++;
      if (alu_b !== 32'd9 || ex_store_data !== 32'd9 || alu_a !== 32'd100) begin
         n_fail++;
         $display("FAIL fwd_mwb: got a=%h b=%h sd=%h want a=64 b=9 sd=9",
                  alu_a, alu_b, ex_store_data);
      end
      clear_id(); clear_fwd();
      id_valid = 1; id_rs = 0; id_rt = 2; id_rs_val = 32'h55;
      id_rt_val = 32'h66; id_functn = 6'b100000;
      sb.push_back('{a: 32'h55, b: 32'h66, f: 6'b100000, v: 1'b1});
      tick();
      exm_reg_write = 1; exm_dest = 0; exm_result = 7;
      #1;
      e = sb.pop_front();
      n_tests++;
      if (alu_a !== e.a || alu_b !== e.b) begin
         n_fail++;
         $display("FAIL fwd_r0: got a=%h b=%h want a=%h b=%h",
                  alu_a, alu_b, e.a, e.b);
      end
      clear_fwd();
   endtask

   task automatic issue_load(input logic [4:0] dst);
      clear_id();
      id_valid = 1; id_rs = 1; id_rs_val = 100; id_imm = 4;
      id_alu_src = 1; id_mem_read = 1; id_reg_write = 1;
      id_dest = dst; id_functn = 6'b100000;
   endtask

   task automatic test_load_use;
      issue_load(5'd4);
      sb.push_back('{a: 32'd100, b: 32'd4, f: 6'b100000, v: 1'b1});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (alu_a !== e.a || alu_b !== e.b || ex_mem_read !== 1'b1) begin
         n_fail++;
         $display("FAIL lw_issue: got a=%h b=%h mr=%b want a=%h b=%h mr=1",
                  alu_a, alu_b, ex_mem_read, e.a, e.b);
      end
      clear_id();
      id_valid = 1; id_rs = 4; id_rt = 5; id_rt_val = 3;
      id_dest = 6; id_reg_write = 1; id_functn = 6'b100000;
      #1;
      n_tests++;
      if (id_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL lu_stall: got %b want 1", id_stall);
      end
      tick();
      exp_stalls++;
      n_tests++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0
          || stall_count !== exp_stalls || id_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL lu_bubble: got v=%b rw=%b mr=%b cnt=%0d st=%b want 0 0 0 %0d 0",
                  ex_valid, ex_reg_write, ex_mem_read, stall_count,
                  id_stall, exp_stalls);
      end
      mwb_reg_write = 1; mwb_dest = 4; mwb_result = 32'hABCD;
      sb.push_back('{a: 32'hABCD, b: 32'd3, f: 6'b100000, v: 1'b1});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (alu_a !== e.a || alu_b !== e.b || ex_valid !== e.v) begin
         n_fail++;
         $display("FAIL lu_replay: got a=%h b=%h v=%b want a=%h b=%h v=%b",
                  alu_a, alu_b, ex_valid, e.a, e.b, e.v);
      end
      clear_fwd();
   endtask

   task automatic test_flush;
      issue_load(5'd7);
      tick();
      clear_id();
      id_valid = 1; id_rs = 1; id_rt = 7; id_mem_write = 1;
      id_alu_src = 1;
      flush = 1;
      #1;
      n_tests++;
      if (id_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL fl_stall: got %b want 1", id_stall);
      end
      tick();
      flush = 0;
      n_tests++;
      if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0
          || stall_count !== exp_stalls) begin
         n_fail++;
         $display("FAIL fl_bubble: got v=%b mw=%b cnt=%0d want 0 0 %0d",
                  ex_valid, ex_mem_write, stall_count, exp_stalls);
      end
   endtask

   task automatic test_lui_sll;
      clear_id();
      id_valid = 1; id_is_lui = 1; id_imm = 16'h1234; id_dest = 8;
      id_reg_write = 1; id_alu_src = 1; id_functn = 6'b100000;
      id_rs_val = 32'hDEAD;
      sb.push_back('{a: 32'h1234_0000, b: 32'd0, f: 6'b100101, v: 1'b1});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (alu_a !== e.a || alu_b !== e.b || alu_functn !== e.f) begin
         n_fail++;
         $display("FAIL lui: got a=%h b=%h f=%b want a=%h b=%h f=%b",
                  alu_a, alu_b, alu_functn, e.a, e.b, e.f);
      end
      clear_id();
      id_valid = 1; id_shift_imm = 1; id_shamt = 31; id_rt = 9;
      id_rt_val = 32'h0000_0003; id_functn = 6'b000000; id_dest = 10;
      sb.push_back('{a: 32'h3, b: 32'd31, f: 6'b000000, v: 1'b1});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (alu_a !== e.a || alu_b !== e.b || alu_functn !== e.f) begin
         n_fail++;
         $display("FAIL sll: got a=%h b=%h f=%b want a=%h b=%h f=%b",
                  alu_a, alu_b, alu_functn, e.a, e.b, e.f);
      end
      clear_id();
      id_valid = 1; id_shift_var = 1; id_rs = 11; id_rt = 12;
      id_rs_val = 32'hFFFF_FFE5; id_rt_val = 32'h80; id_functn = 6'b000100;
      sb.push_back('{a: 32'h80, b: 32'd5, f: 6'b000100, v: 1'b1});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (alu_a !== e.a || alu_b !== e.b || alu_functn !== e.f) begin
         n_fail++;
         $display("FAIL sllv: got a=%h b=%h f=%b want a=%h b=%h f=%b",
                  alu_a, alu_b, alu_functn, e.a, e.b, e.f);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rsv, rtv;
      logic [15:0] im;
      logic        src, zx;
      for (int i = 0; i < 8; i++) begin
         rsv = $urandom; rtv = $urandom;
         im = 16'($urandom); src = 1'($urandom); zx = 1'($urandom);
         clear_id();
         id_valid = 1; id_rs = 5'($urandom_range(1, 31));
         id_rt = 5'($urandom_range(1, 31));
         id_rs_val = rsv; id_rt_val = rtv; id_imm = im;
         id_alu_src = src; id_imm_zext = zx; id_functn = 6'b100010;
         sb.push_back('{a: rsv,
                        b: !src ? rtv : zx ? {16'h0, im} : {{16{im[15]}}, im},
                        f: 6'b100010, v: 1'b1});
         tick();
         e = sb.pop_front();
         n_tests++;
         if (alu_a !== e.a || alu_b !== e.b || alu_functn !== e.f
             || ex_valid !== e.v) begin
            n_fail++;
            $display("FAIL b2b_%0d: got a=%h b=%h f=%b v=%b want a=%h b=%h f=%b v=%b",
                     i, alu_a, alu_b, alu_functn, ex_valid,
                     e.a, e.b, e.f, e.v);
         end
      end
   endtask

   task automatic test_reset_mid;
      clear_id();
      id_valid = 1; id_rs = 3; id_rs_val = 32'h1111; id_rt = 4;
      id_rt_val = 32'h2222; id_dest = 5; id_reg_write = 1;
      id_functn = 6'b100000;
      tick();
      n_tests++;
      if (ex_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_pre: got v=%b want 1", ex_valid);
      end
      reset = 1; flush = 1;
      tick();
      n_tests++;
      if ({alu_a, alu_b, alu_functn, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_dest, ex_store_data, stall_count} !== 143'd0) begin
         n_fail++;
         $display("FAIL rm_clear: got a=%h b=%h f=%b v=%b d=%0d cnt=%0d want 0",
                  alu_a, alu_b, alu_functn, ex_valid, ex_dest, stall_count);
      end
      reset = 0; flush = 0;
      clear_id();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_forward();
      test_load_use();
      test_flush();
      test_lui_sll();
      test_back_to_back();
      test_reset_mid();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d left want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_rs_val, id_rt_val  in  32 each  register-file read data.
REQ-006 id_imm  in  16  immediate field; id_shamt  in  5  shift amount.
REQ-007 id_functn  in  6  ALU function code, in the ALU's encoding.
REQ-008 id_rs, id_rt, id_dest  in  5 each  source and destination register indices.
REQ-009 id_reg_write, id_mem_read, id_mem_write  in  1 each  downstream controls.
REQ-010 id_alu_src, id_imm_zext, id_shift_imm, id_shift_var, id_is_lui  in  1 each  operand-select controls.
REQ-011 flush  in  1  kill the instruction entering EX.
REQ-012 exm_reg_write  in  1; exm_dest  in  5; exm_result  in  32  EX/MEM forwarding source.
REQ-013 mwb_reg_write  in  1; mwb_dest  in  5; mwb_result  in  32  MEM/WB forwarding source.
REQ-014 alu_a, alu_b  out  32 each  ALU operands; alu_functn  out  6  ALU function code.
REQ-015 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each; ex_dest  out  5.
REQ-016 ex_store_data  out  32  forwarded rt value for stores.
REQ-017 id_stall  out  1  load-use hold request to fetch/decode; stall_count  out  32  count of inserted bubbles.

Function
REQ-018 Every rising edge with no stall, flush or reset SHALL latch all id_* inputs into the EX register; ex_valid is then id_valid.
REQ-019 id_stall SHALL be combinational and asserted when all hold: id_valid=1; ex_valid=1; ex_mem_read=1; ex_dest!=0; ex_dest equals id_rs, or equals id_rt when the instruction reads rt (id_alu_src=0, id_shift_imm=1, id_shift_var=1 or id_mem_write=1).
REQ-020 On an edge with id_stall=1, the EX register SHALL load a bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write all 0, other fields don't-care. stall_count increments, saturating at 32'hFFFFFFFF.
REQ-021 On an edge with flush=1, the EX register SHALL load a bubble; flush has priority over stall; stall_count does not increment.
REQ-022 Forwarding SHALL be combinational from registered rs_val/rt_val. Priority: EX/MEM (exm_reg_write=1, exm_dest!=0, match) > MEM/WB (same rule) > registered value. Register 0 is never forwarded.
REQ-023 Operand A SHALL be: id_is_lui -> {imm,16'h0}; shift_imm or shift_var -> fwd_rt; otherwise fwd_rs.
REQ-024 Operand B SHALL be: is_lui -> 0; shift_imm -> zero-extended shamt; shift_var -> zero-extended fwd_rs[4:0]; alu_src -> immediate, zero-extended if imm_zext and sign-extended otherwise; else fwd_rt.
REQ-025 alu_functn SHALL be forced to OR (6'b100101) when is_lui is set; otherwise it is the registered functn.
REQ-026 ex_store_data SHALL be fwd_rt. Latency is one cycle from the decode inputs to the alu_* outputs, with zero added latency for forwarded data.

Reset
REQ-027 A reset edge SHALL clear every EX register field and stall_count to 0, so alu_a=alu_b=0, alu_functn=6'b000000 and all ex_* outputs are 0.
REQ-028 Reset SHALL dominate flush and stall. An instruction in flight at reset is discarded and not replayed.

Structure
REQ-029 A shared package SHALL hold the ALU function-code constants (ADD 100000, SUB 100010, OR 100101, SLL 000000, ...) and the forwarding-select enum FWD_REG/FWD_EXM/FWD_MWB.
REQ-030 Forwarding SHALL be one sub-module, fwd_mux, instantiated once for rs and once for rt.

Verification
REQ-031 ADDI with rs_val=5, imm=16'hFFFF, imm_zext=0 -> next cycle alu_a=5, alu_b=32'hFFFFFFFF, alu_functn=001000.
REQ-032 ADD r3=r1+r2 with exm_dest=1 (exm_result=7) and mwb_dest=1 (mwb_result=9) -> alu_a=7, showing EX/MEM priority. With exm_dest=0 and exm_reg_write=1 -> no forward.
REQ-033 LW r4 in EX followed by an ADD reading r4 -> id_stall=1 for one cycle, the bubble gives ex_valid=0, stall_count=1, and the ADD enters next edge with alu_a = mwb_result.
REQ-034 flush=1 together with a load-use stall -> bubble inserted, stall_count unchanged.
REQ-035 LUI imm=16'h1234 -> alu_a=32'h12340000, alu_b=0, alu_functn=100101. SLL with shamt=31 -> alu_b=31.
REQ-036 reset asserted mid-stream with ex_valid=1 -> next edge all outputs 0 and stall_count=0.
